// File: rtl/ws2812_strand_driver_pkg.sv
// ws2812_strand_driver_pkg: shared states, 100 MHz timing defaults and pixel type for the WS2812 strand driver
package ws2812_strand_driver_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, SEND_HIGH, SEND_LOW, LATCH} state_t;
    localparam int DEF_NUM_LEDS = 20;
    localparam int DEF_COLOR_WIDTH = 8;
    localparam int DEF_T0H_CYCLES = 40;
    localparam int DEF_T0L_CYCLES = 85;
    localparam int DEF_T1H_CYCLES = 80;
    localparam int DEF_T1L_CYCLES = 45;
    localparam int DEF_RESET_CYCLES = 8000;
    localparam int DEF_REQ_LATENCY = 2;
    typedef struct packed {
        logic [DEF_COLOR_WIDTH-1:0] green;
        logic [DEF_COLOR_WIDTH-1:0] red;
        logic [DEF_COLOR_WIDTH-1:0] blue;
    } grb_t;
    function automatic int cnt_width(input int a, input int b, input int c, input int d, input int e, input int f);
        int m;
        m = a;
        m = b > m ? b : m;
        m = c > m ? c : m;
        m = d > m ? d : m;
        m = e > m ? e : m;
        m = f > m ? f : m;
        return $clog2(m + 1);
    endfunction
endpackage

// File: rtl/ws2812_strand_driver_if.sv
// ws2812_strand_driver_if: LED pixel-request channel between the strand driver and a pattern source
interface ws2812_strand_driver_if #(
    parameter int COLOR_WIDTH = 8,
    parameter int LED_COUNTER_WIDTH = 5
);
    logic [LED_COUNTER_WIDTH-1:0] next_led_request_out;
    logic request_valid_out;
    logic [COLOR_WIDTH-1:0] green_in;
    logic [COLOR_WIDTH-1:0] red_in;
    logic [COLOR_WIDTH-1:0] blue_in;
    logic color_ready_in;
    modport master (
        output next_led_request_out, request_valid_out,
        input green_in, red_in, blue_in, color_ready_in
    );
    modport slave (
        input next_led_request_out, request_valid_out,
        output green_in, red_in, blue_in, color_ready_in
    );
endinterface

// File: rtl/ws2812_bit_tx.sv
// ws2812_bit_tx: emits one NRZ bit (high then low phase) per start pulse
module ws2812_bit_tx #(
    parameter int T0H_CYCLES = 40,
    parameter int T0L_CYCLES = 85,
    parameter int T1H_CYCLES = 80,
    parameter int T1L_CYCLES = 45,
    parameter int TW = 8
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic start,
    input  logic bit_val,
    output logic line,
    output logic high_end,
    output logic done
);
    logic active;
    logic bit_r;
    logic [TW-1:0] cnt;
    logic [TW-1:0] hi_last;
    logic [TW-1:0] lo_last;
    assign hi_last = bit_r ? TW'(T1H_CYCLES - 1) : TW'(T0H_CYCLES - 1);
    assign lo_last = bit_r ? TW'(T1L_CYCLES - 1) : TW'(T0L_CYCLES - 1);
    assign high_end = active && line && cnt == hi_last;
    assign done = active && !line && cnt == lo_last;
    // start may coincide with done so consecutive bits chain without a gap
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            line <= 1'b0;
            active <= 1'b0;
            bit_r <= 1'b0;
            cnt <= '0;
        end else if (start) begin
            line <= 1'b1;
            active <= 1'b1;
            bit_r <= bit_val;
            cnt <= '0;
        end else if (high_end) begin
            line <= 1'b0;
            cnt <= '0;
        end else if (done) begin
            active <= 1'b0;
        end else if (active) begin
            cnt <= cnt + TW'(1);
        end
    end
endmodule

// File: rtl/ws2812_strand_driver.sv
// ws2812_strand_driver: fetches GRB pixels by index and streams them out as a WS2812 frame
module ws2812_strand_driver
    import ws2812_strand_driver_pkg::*;
#(
    parameter int NUM_LEDS = DEF_NUM_LEDS,
    parameter int COLOR_WIDTH = DEF_COLOR_WIDTH,
    parameter int T0H_CYCLES = DEF_T0H_CYCLES,
    parameter int T0L_CYCLES = DEF_T0L_CYCLES,
    parameter int T1H_CYCLES = DEF_T1H_CYCLES,
    parameter int T1L_CYCLES = DEF_T1L_CYCLES,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int REQ_LATENCY = DEF_REQ_LATENCY
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic enable_in,
    ws2812_strand_driver_if.master px,
    output logic strand_out,
    output logic busy_out,
    output logic frame_done_out
);
    localparam int LED_COUNTER_WIDTH = NUM_LEDS > 1 ? $clog2(NUM_LEDS) : 1;
    localparam int LW = LED_COUNTER_WIDTH;
    localparam int PW = 3 * COLOR_WIDTH;
    localparam int BW = $clog2(PW);
    localparam int TW = cnt_width(RESET_CYCLES, REQ_LATENCY, T0H_CYCLES, T0L_CYCLES, T1H_CYCLES, T1L_CYCLES);
    if (T0H_CYCLES >= T1H_CYCLES || T0H_CYCLES < 1 || T0L_CYCLES < 1 || T1H_CYCLES < 1 || T1L_CYCLES < 1
        || RESET_CYCLES < 1 || REQ_LATENCY < 1 || NUM_LEDS < 1) begin : g_bad_params
        $error("ws2812_strand_driver: illegal timing parameters");
    end
    state_t state, state_nxt;
    logic [TW-1:0] cnt, pf_cnt;
    logic [BW-1:0] bit_cnt;
    logic [PW-1:0] shift, shadow, fetch_color;
    logic [LW-1:0] idx, idx_inc, cur, pf_idx;
    logic pf_busy, pf_last, pf_go, pix_start;
    logic fetch_last, latch_last, last_bit, pix_last;
    logic tx_start, tx_bit, tx_high_end, tx_done;
    assign fetch_color = px.color_ready_in ? {px.green_in, px.red_in, px.blue_in} : '0;
    assign fetch_last = state == FETCH && cnt == TW'(REQ_LATENCY - 1);
    assign latch_last = state == LATCH && cnt == TW'(RESET_CYCLES - 1);
    assign last_bit = bit_cnt == '0;
    assign pix_last = idx == LW'(NUM_LEDS - 1);
    assign idx_inc = idx + LW'(1);
    assign pf_last = pf_cnt == TW'(REQ_LATENCY - 1);
    assign pix_start = fetch_last || (state == SEND_LOW && tx_done && last_bit && !pix_last);
    assign cur = state == FETCH ? '0 : idx_inc;
    assign pf_go = pix_start && int'(cur) < NUM_LEDS - 1;
    assign pf_idx = cur + LW'(1);
    assign tx_bit = state == FETCH ? fetch_color[PW-1] : last_bit ? shadow[PW-1] : shift[PW-2];
    ws2812_bit_tx #(
        .T0H_CYCLES(T0H_CYCLES), .T0L_CYCLES(T0L_CYCLES),
        .T1H_CYCLES(T1H_CYCLES), .T1L_CYCLES(T1L_CYCLES), .TW(TW)
    ) u_tx (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .start(tx_start), .bit_val(tx_bit),
        .line(strand_out), .high_end(tx_high_end), .done(tx_done)
    );
    // state register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= IDLE;
        else state <= state_nxt;
    end
    // next state and bit launch; a busy IDLE means the latch exit chose to continue
    always_comb begin
        state_nxt = state;
        tx_start = 1'b0;
        case (state)
            IDLE: if (enable_in || busy_out) state_nxt = FETCH;
            FETCH: if (fetch_last) begin
                state_nxt = SEND_HIGH;
                tx_start = 1'b1;
            end
            SEND_HIGH: if (tx_high_end) state_nxt = SEND_LOW;
            SEND_LOW: if (tx_done) begin
                state_nxt = last_bit && pix_last ? LATCH : SEND_HIGH;
                tx_start = !(last_bit && pix_last);
            end
            LATCH: if (latch_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    // index, request, shift/shadow registers and frame status; a new prefetch overrides a drop of request_valid
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt <= '0;
            pf_cnt <= '0;
            pf_busy <= 1'b0;
            bit_cnt <= '0;
            shift <= '0;
            shadow <= '0;
            idx <= '0;
            busy_out <= 1'b0;
            frame_done_out <= 1'b0;
            px.next_led_request_out <= '0;
            px.request_valid_out <= 1'b0;
        end else begin
            frame_done_out <= latch_last;
            cnt <= cnt + TW'(1);
            if (pf_busy) begin
                pf_cnt <= pf_cnt + TW'(1);
                if (pf_last) begin
                    shadow <= fetch_color;
                    pf_busy <= 1'b0;
                    px.request_valid_out <= 1'b0;
                end
            end
            if (state == IDLE && state_nxt == FETCH) begin
                busy_out <= 1'b1;
                cnt <= '0;
                idx <= '0;
                px.next_led_request_out <= '0;
                px.request_valid_out <= 1'b1;
            end
            if (fetch_last) begin
                shift <= fetch_color;
                bit_cnt <= BW'(PW - 1);
                px.request_valid_out <= 1'b0;
            end
            if (state == SEND_LOW && tx_done) begin
                shift <= last_bit ? shadow : shift << 1;
                bit_cnt <= last_bit ? BW'(PW - 1) : bit_cnt - BW'(1);
                if (last_bit) idx <= pix_last ? '0 : idx_inc;
                if (last_bit && pix_last) begin
                    cnt <= '0;
                    px.next_led_request_out <= '0;
                end
            end
            if (latch_last) busy_out <= enable_in;
            if (pf_go) begin
                pf_busy <= 1'b1;
                pf_cnt <= '0;
                px.next_led_request_out <= pf_idx;
                px.request_valid_out <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ws2812_strand_driver.sv
// tb_ws2812_strand_driver: directed checks of a 3-LED strand with short bit timings
module tb_ws2812_strand_driver;
    import ws2812_strand_driver_pkg::*;
    localparam int LW = 2;
    localparam grb_t PAT = '{green: 8'hA5, red: 8'h00, blue: 8'hFF};
    logic clk_in = 1'b0;
    logic rst_n_in = 1'b0;
    logic enable_in = 1'b0;
    logic strand_out, busy_out, frame_done_out;
    int vectors = 0;
    int errs = 0;
    int cyc = 0;
    int hq[$];
    int lq[$];
    int fd_q[$];
    logic [LW-1:0] seq[$];
    int vcount[4];
    int run = 0;
    int age = 0;
    int rise_cyc = 0;
    int fall_cyc = 0;
    int start_cyc = 0;
    bit started = 1'b0;
    bit black1 = 1'b0;
    logic prev_s = 1'b0;
    logic prev_valid = 1'b0;
    logic [LW-1:0] prev_req = '0;
    ws2812_strand_driver_if #(.COLOR_WIDTH(8), .LED_COUNTER_WIDTH(LW)) px();
    ws2812_strand_driver #(
        .NUM_LEDS(3), .COLOR_WIDTH(8), .T0H_CYCLES(2), .T0L_CYCLES(4),
        .T1H_CYCLES(4), .T1L_CYCLES(2), .RESET_CYCLES(10), .REQ_LATENCY(2)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .enable_in(enable_in), .px(px),
        .strand_out(strand_out), .busy_out(busy_out), .frame_done_out(frame_done_out)
    );
    always #5 clk_in = ~clk_in;
    assign px.green_in = PAT.green;
    assign px.red_in = PAT.red;
    assign px.blue_in = PAT.blue;
    assign px.color_ready_in = age == 2 && !(black1 && px.next_led_request_out == LW'(1));
    always @(posedge clk_in) cyc <= cyc + 1;
    always @(negedge clk_in) begin
        if (strand_out !== prev_s) begin
            if (prev_s) begin
                hq.push_back(run);
                fall_cyc = cyc;
            end else if (started) lq.push_back(run);
            if (strand_out && !started) begin
                started = 1'b1;
                rise_cyc = cyc;
            end
            run = 1;
        end else run++;
        prev_s = strand_out;
        if (frame_done_out) fd_q.push_back(cyc);
        if (px.request_valid_out) vcount[px.next_led_request_out]++;
        if (px.next_led_request_out !== prev_req) seq.push_back(px.next_led_request_out);
        age = !px.request_valid_out ? 0 : (prev_valid && px.next_led_request_out == prev_req) ? age + 1 : 1;
        prev_req = px.next_led_request_out;
        prev_valid = px.request_valid_out;
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    task automatic tick();
        @(negedge clk_in);
        #1;
    endtask
    task automatic clear_rec();
        hq.delete();
        lq.delete();
        fd_q.delete();
        seq.delete();
        vcount = '{default: 0};
        started = 1'b0;
    endtask
    task automatic wait_fd(input int n);
        int k;
        k = 0;
        while (fd_q.size() < n && k < 1500) begin
            tick();
            k++;
        end
        chk("frame_done_wait", 32'(fd_q.size() >= n), 1);
    endtask
    function automatic int exp_hi(input int p, input int b);
        logic [23:0] c;
        c = (black1 && p == 1) ? 24'h0 : PAT;
        return c[23-b] ? 4 : 2;
    endfunction
    task automatic check_frame(input int f);
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < 24; b++) begin
                int k;
                k = f * 72 + p * 24 + b;
                chk("pulse_high", k < hq.size() ? hq[k] : -1, exp_hi(p, b));
                if (p * 24 + b < 71) chk("pulse_low", k < lq.size() ? lq[k] : -1, 6 - exp_hi(p, b));
            end
        end
    endtask
    task automatic check_requests();
        chk("req_seq_len", seq.size(), 3);
        chk("req_seq0", seq.size() > 0 ? seq[0] : 3, 1);
        chk("req_seq1", seq.size() > 1 ? seq[1] : 3, 2);
        chk("req_seq2", seq.size() > 2 ? seq[2] : 3, 0);
        for (int i = 0; i < 3; i++) chk("req_valid_cycles", vcount[i], 2);
    endtask
    initial begin
        repeat (3) tick();
        chk("rst_strand", strand_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_frame_done", frame_done_out, 0);
        chk("rst_req", px.next_led_request_out, 0);
        chk("rst_valid", px.request_valid_out, 0);
        rst_n_in = 1'b1;
        repeat (3) tick();
        chk("idle_strand", strand_out, 0);
        chk("idle_busy", busy_out, 0);
        clear_rec();
        enable_in = 1'b1;
        tick();
        enable_in = 1'b0;
        start_cyc = cyc;
        chk("start_valid", px.request_valid_out, 1);
        chk("start_req", px.next_led_request_out, 0);
        chk("start_busy", busy_out, 1);
        tick();
        tick();
        chk("mid_busy", busy_out, 1);
        wait_fd(1);
        chk("fd_pulse", frame_done_out, 1);
        chk("fd_time", fd_q.size() > 0 ? fd_q[0] - start_cyc : -1, 444);
        chk("first_rise", rise_cyc - start_cyc, 2);
        chk("latch_low", fd_q.size() > 0 ? fd_q[0] - fall_cyc : -1, 12);
        chk("busy_after_latch", busy_out, 0);
        tick();
        chk("fd_one_cycle", frame_done_out, 0);
        chk("pulse_count", hq.size(), 72);
        check_frame(0);
        check_requests();
        repeat (500) tick();
        chk("single_frame_fd", fd_q.size(), 1);
        chk("single_frame_pulses", hq.size(), 72);
        chk("idle_busy2", busy_out, 0);
        chk("idle_valid2", px.request_valid_out, 0);
        clear_rec();
        black1 = 1'b1;
        enable_in = 1'b1;
        tick();
        wait_fd(2);
        enable_in = 1'b0;
        chk("frame_period", fd_q.size() > 1 ? fd_q[1] - fd_q[0] : -1, 445);
        chk("interframe_low", lq.size() > 71 ? lq[71] : -1, 15);
        check_frame(0);
        check_frame(1);
        wait_fd(3);
        chk("busy_drop", busy_out, 0);
        repeat (20) tick();
        chk("three_frames_fd", fd_q.size(), 3);
        chk("three_frames_pulses", hq.size(), 216);
        chk("final_valid", px.request_valid_out, 0);
        black1 = 1'b0;
        clear_rec();
        enable_in = 1'b1;
        tick();
        enable_in = 1'b0;
        for (int k = 0; k < 200 && !(hq.size() >= 5 && strand_out); k++) tick();
        chk("in_send_high", strand_out, 1);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk("async_strand", strand_out, 0);
        chk("async_busy", busy_out, 0);
        chk("async_valid", px.request_valid_out, 0);
        chk("async_req", px.next_led_request_out, 0);
        chk("async_fd", frame_done_out, 0);
        tick();
        tick();
        rst_n_in = 1'b1;
        tick();
        clear_rec();
        enable_in = 1'b1;
        tick();
        enable_in = 1'b0;
        chk("restart_valid", px.request_valid_out, 1);
        chk("restart_req", px.next_led_request_out, 0);
        chk("restart_busy", busy_out, 1);
        wait_fd(1);
        chk("restart_pulses", hq.size(), 72);
        check_frame(0);
        check_requests();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
